// File: rtl/ahb_lite_arb2.sv
// Two-master AHB-Lite arbiter: registers each master's address phase and replays it on a shared slave bus.
// Define ARB2_FIXED_PRIO_EN for fixed M0-first priority instead of round-robin.
module ahb_lite_arb2 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic              M0_HREADY,
  output logic [DATA_W-1:0] M0_HRDATA,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic              M1_HREADY,
  output logic [DATA_W-1:0] M1_HRDATA,
  output logic [ADDR_W-1:0] S_HADDR,
  output logic [1:0]        S_HTRANS,
  output logic              S_HWRITE,
  output logic [2:0]        S_HSIZE,
  output logic [DATA_W-1:0] S_HWDATA,
  output logic              S_HREADY,
  input  logic              S_HREADYOUT,
  input  logic [DATA_W-1:0] S_HRDATA
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  logic              pend0_q, pend0_d, pend1_q, pend1_d;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic              write0_q, write1_q;
  logic [2:0]        size0_q, size1_q;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_owner_q, dp_owner_d;
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
`ifndef ARB2_FIXED_PRIO_EN
  logic              last_grant_q;
`endif

  logic grant, winner, grant0, grant1, cap0, cap1;

  always_comb begin
    grant = S_HREADYOUT && (pend0_q || pend1_q);
`ifdef ARB2_FIXED_PRIO_EN
    winner = !pend0_q;
`else
    // Tie goes to whoever did not win last; otherwise the sole requester.
    winner = (pend0_q && pend1_q) ? !last_grant_q : !pend0_q;
`endif
    grant0 = grant && !winner;
    grant1 = grant && winner;
  end

  assign M0_HREADY = !pend0_q && !(dp_valid_q && !dp_owner_q && !S_HREADYOUT) && !grant0;
  assign M1_HREADY = !pend1_q && !(dp_valid_q &&  dp_owner_q && !S_HREADYOUT) && !grant1;
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;

  assign cap0 = M0_HREADY && (M0_HTRANS == HTRANS_NONSEQ || M0_HTRANS == HTRANS_SEQ);
  assign cap1 = M1_HREADY && (M1_HTRANS == HTRANS_NONSEQ || M1_HTRANS == HTRANS_SEQ);

  assign S_HTRANS = grant ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign S_HADDR  = grant ? (winner ? addr1_q  : addr0_q)  : haddr_q;
  assign S_HWRITE = grant ? (winner ? write1_q : write0_q) : hwrite_q;
  assign S_HSIZE  = grant ? (winner ? size1_q  : size0_q)  : hsize_q;
  assign S_HWDATA = dp_owner_q ? M1_HWDATA : M0_HWDATA;
  assign S_HREADY = S_HREADYOUT;

  always_comb begin
    pend0_d    = cap0 ? 1'b1 : (grant0 ? 1'b0 : pend0_q);
    pend1_d    = cap1 ? 1'b1 : (grant1 ? 1'b0 : pend1_q);
    dp_valid_d = S_HREADYOUT ? grant : dp_valid_q;
    dp_owner_d = grant ? winner : dp_owner_q;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      addr0_q    <= '0;
      addr1_q    <= '0;
      write0_q   <= 1'b0;
      write1_q   <= 1'b0;
      size0_q    <= '0;
      size1_q    <= '0;
      dp_valid_q <= 1'b0;
      dp_owner_q <= 1'b0;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hsize_q    <= '0;
`ifndef ARB2_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      dp_valid_q <= dp_valid_d;
      dp_owner_q <= dp_owner_d;
      if (cap0) begin
        addr0_q  <= M0_HADDR;
        write0_q <= M0_HWRITE;
        size0_q  <= M0_HSIZE;
      end
      if (cap1) begin
        addr1_q  <= M1_HADDR;
        write1_q <= M1_HWRITE;
        size1_q  <= M1_HSIZE;
      end
      // Idle slave bus keeps presenting the last issued address.
      haddr_q  <= S_HADDR;
      hwrite_q <= S_HWRITE;
      hsize_q  <= S_HSIZE;
`ifndef ARB2_FIXED_PRIO_EN
      if (grant) last_grant_q <= winner;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// Bench for ahb_lite_arb2: directed scenarios with literal expectations plus
// randomized masters/slave checked every cycle against a request-level model.
module tb_ahb_lite_arb2;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE, M0_HREADY, M1_HREADY;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [1:0]  S_HTRANS;
  logic        S_HWRITE, S_HREADY, S_HREADYOUT;
  logic [2:0]  S_HSIZE;

  int errors = 0;
  int checks = 0;
  logic rdy_seen [2];

  ahb_lite_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA),
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
    .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Request-level model: each master has at most one outstanding request; the slave
  // bus serves one request per ready cycle, choosing by preference on a tie.
  bit          mp [2];
  logic [31:0] ma [2];
  logic        mw [2];
  logic [2:0]  ms [2];
  bit          dv;
  int          dpo;
  int          pref;
  logic [31:0] ha;
  logic        hw;
  logic [2:0]  hs;
  bit          live = 0;
  int          win;
  bit          er [2];

  initial forever begin
    @(negedge HCLK);
    rdy_seen[0] = M0_HREADY;
    rdy_seen[1] = M1_HREADY;
    if (live) begin
      logic [31:0] ea;
      logic        ew;
      logic [2:0]  es;
      win = -1;
      if (S_HREADYOUT) begin
        if (mp[0] && mp[1]) win = pref;
        else if (mp[0])     win = 0;
        else if (mp[1])     win = 1;
      end
      for (int i = 0; i < 2; i++)
        er[i] = !mp[i] && !(dv && dpo == i && !S_HREADYOUT) && (win != i);
      ea = ha; ew = hw; es = hs;
      if (win >= 0) begin ea = ma[win]; ew = mw[win]; es = ms[win]; end
      chk("m_M0_HREADY", 32'(M0_HREADY), 32'(er[0]));
      chk("m_M1_HREADY", 32'(M1_HREADY), 32'(er[1]));
      chk("m_S_HTRANS", 32'(S_HTRANS), (win >= 0) ? 32'h2 : 32'h0);
      chk("m_S_HADDR", S_HADDR, ea);
      chk("m_S_HWRITE", 32'(S_HWRITE), 32'(ew));
      chk("m_S_HSIZE", 32'(S_HSIZE), 32'(es));
      chk("m_S_HREADY", 32'(S_HREADY), 32'(S_HREADYOUT));
      chk("m_M0_HRDATA", M0_HRDATA, S_HRDATA);
      chk("m_M1_HRDATA", M1_HRDATA, S_HRDATA);
      if (dv) chk("m_S_HWDATA", S_HWDATA, (dpo == 1) ? M1_HWDATA : M0_HWDATA);
    end
    @(posedge HCLK);
    if (HRESET) begin
      mp[0] = 0; mp[1] = 0; dv = 0; dpo = 0; pref = 0;
      ha = '0; hw = 1'b0; hs = '0; live = 1;
      er[0] = 0; er[1] = 0;
    end else if (live) begin
      if (win >= 0) begin
        ha = ma[win]; hw = mw[win]; hs = ms[win];
        mp[win] = 0; dv = 1; dpo = win;
`ifndef ARB2_FIXED_PRIO_EN
        pref = 1 - win;
`endif
      end else if (S_HREADYOUT) begin
        dv = 0;
      end
      if (er[0] && M0_HTRANS[1]) begin mp[0] = 1; ma[0] = M0_HADDR; mw[0] = M0_HWRITE; ms[0] = M0_HSIZE; end
      if (er[1] && M1_HTRANS[1]) begin mp[1] = 1; ma[1] = M1_HADDR; mw[1] = M1_HWRITE; ms[1] = M1_HSIZE; end
    end
  end

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic drv(input int m, input logic [1:0] tr, input logic [31:0] a, input logic w);
    if (m == 0) begin M0_HTRANS = tr; M0_HADDR = a; M0_HWRITE = w; M0_HSIZE = 3'd2; end
    else        begin M1_HTRANS = tr; M1_HADDR = a; M1_HWRITE = w; M1_HSIZE = 3'd2; end
  endtask

  task automatic rnd_master(input int m);
    logic [1:0]  tr;
    logic [31:0] a, d;
    logic        w;
    logic [2:0]  s;
    tr = 2'($urandom_range(0, 3));
    a  = $urandom;
    d  = $urandom;
    w  = 1'($urandom_range(0, 1));
    s  = 3'($urandom_range(0, 2));
    if (m == 0) begin M0_HTRANS = tr; M0_HADDR = a; M0_HWRITE = w; M0_HSIZE = s; M0_HWDATA = d; end
    else        begin M1_HTRANS = tr; M1_HADDR = a; M1_HWRITE = w; M1_HSIZE = s; M1_HWDATA = d; end
  endtask

  initial begin
    int lows;
    HRESET = 1'b1;
    drv(0, 2'b00, 32'h0, 1'b0);
    drv(1, 2'b00, 32'h0, 1'b0);
    M0_HWDATA = '0; M1_HWDATA = '0;
    S_HREADYOUT = 1'b1; S_HRDATA = '0;
    repeat (2) cyc();
    HRESET = 1'b0;
    mid();
    chk("rst_M0_HREADY", 32'(M0_HREADY), 32'h1);
    chk("rst_M1_HREADY", 32'(M1_HREADY), 32'h1);
    chk("rst_S_HTRANS", 32'(S_HTRANS), 32'h0);
    chk("rst_S_HADDR", S_HADDR, 32'h0);
    chk("rst_S_HWRITE", 32'(S_HWRITE), 32'h0);
    chk("rst_S_HSIZE", 32'(S_HSIZE), 32'h0);

    // Single read with zero slave wait states.
    S_HRDATA = 32'h0000_0101;
    cyc(); drv(0, 2'b10, 32'h4, 1'b0);
    cyc(); mid();
    chk("rd_S_HTRANS", 32'(S_HTRANS), 32'h2);
    chk("rd_S_HADDR", S_HADDR, 32'h4);
    chk("rd_M0_wait", 32'(M0_HREADY), 32'h0);
    M0_HTRANS = 2'b00;
    cyc(); mid();
    chk("rd_M0_done", 32'(M0_HREADY), 32'h1);
    chk("rd_M0_HRDATA", M0_HRDATA, 32'h0000_0101);

    // Write with two slave wait states.
    cyc(); drv(0, 2'b10, 32'h2000_0000, 1'b1);
    lows = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) begin M0_HTRANS = 2'b00; M0_HWDATA = 32'hDEAD_BEEF; end
      S_HREADYOUT = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      mid();
      if (!M0_HREADY) lows++;
      chk("wr_M1_HREADY", 32'(M1_HREADY), 32'h1);
      if (k == 0) chk("wr_S_HWRITE", 32'(S_HWRITE), 32'h1);
      if (k > 0)  chk("wr_S_HWDATA", S_HWDATA, 32'hDEAD_BEEF);
    end
    chk("wr_M0_low_cycles", 32'(lows), 32'h3);

    // Simultaneous requests after reset, then a tie after a lone M0 transfer.
    cyc(); HRESET = 1'b1;
    cyc(); HRESET = 1'b0;
    drv(0, 2'b10, 32'h100, 1'b0);
    drv(1, 2'b10, 32'h200, 1'b0);
    cyc(); M0_HTRANS = 2'b00; M1_HTRANS = 2'b00; mid();
    chk("tie1_first", S_HADDR, 32'h100);
    cyc(); mid();
    chk("tie1_second", S_HADDR, 32'h200);
    cyc(); drv(0, 2'b10, 32'h180, 1'b0);
    cyc(); M0_HTRANS = 2'b00;
    cyc();
    drv(0, 2'b10, 32'h300, 1'b0);
    drv(1, 2'b10, 32'h400, 1'b0);
    cyc(); M0_HTRANS = 2'b00; M1_HTRANS = 2'b00; mid();
`ifdef ARB2_FIXED_PRIO_EN
    chk("tie2_first", S_HADDR, 32'h300);
    cyc(); mid();
    chk("tie2_second", S_HADDR, 32'h400);
`else
    chk("tie2_first", S_HADDR, 32'h400);
    cyc(); mid();
    chk("tie2_second", S_HADDR, 32'h300);
`endif

    // Back-to-back M0: second address captured in the cycle the first completes.
    repeat (2) cyc();
    drv(0, 2'b10, 32'h0, 1'b0);
    cyc(); drv(0, 2'b11, 32'h4, 1'b0); mid();
    chk("b2b_a_trans", 32'(S_HTRANS), 32'h2);
    chk("b2b_a_addr", S_HADDR, 32'h0);
    cyc(); mid();
    chk("b2b_cap_rdy", 32'(M0_HREADY), 32'h1);
    chk("b2b_gap_trans", 32'(S_HTRANS), 32'h0);
    cyc(); M0_HTRANS = 2'b00; mid();
    chk("b2b_b_trans", 32'(S_HTRANS), 32'h2);
    chk("b2b_b_addr", S_HADDR, 32'h4);

    // Reset while M1's data phase is stalled and M0 is pending.
    repeat (2) cyc();
    drv(1, 2'b10, 32'h500, 1'b0);
    cyc(); M1_HTRANS = 2'b00; drv(0, 2'b10, 32'h600, 1'b1); mid();
    chk("rs_M1_addr", S_HADDR, 32'h500);
    cyc(); S_HREADYOUT = 1'b0; mid();
    chk("rs_M1_stall", 32'(M1_HREADY), 32'h0);
    chk("rs_M0_pend", 32'(M0_HREADY), 32'h0);
    M0_HTRANS = 2'b00; HRESET = 1'b1;
    cyc(); HRESET = 1'b0; S_HREADYOUT = 1'b1; mid();
    chk("rs_M0_HREADY", 32'(M0_HREADY), 32'h1);
    chk("rs_M1_HREADY", 32'(M1_HREADY), 32'h1);
    chk("rs_S_HTRANS", 32'(S_HTRANS), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(); mid();
      chk("rs_no_replay", 32'(S_HTRANS), 32'h0);
    end

    // BUSY and IDLE are never captured.
    for (int k = 0; k < 4; k++) begin
      cyc();
      drv(0, (k % 2 == 0) ? 2'b01 : 2'b00, 32'h700 + 32'(k), 1'b0);
      mid();
      chk("busy_S_HTRANS", 32'(S_HTRANS), 32'h0);
      chk("busy_M0_HREADY", 32'(M0_HREADY), 32'h1);
    end

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      HRESET = ($urandom_range(0, 499) == 0);
      if (rdy_seen[0]) rnd_master(0);
      if (rdy_seen[1]) rnd_master(1);
      S_HREADYOUT = ($urandom_range(0, 3) != 0);
      S_HRDATA = $urandom;
    end
    HRESET = 1'b0;
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
